ep2_event_dispatch: RTL and testbench
=====================================

Name: ep2_event_dispatch

Overview:
- Parametrised buffered channel that sits between two EP2 handler stages in the generated top level.
- Replaces direct handler-to-handler wiring and tied-off tready with a real FIFO that applies backpressure.
- Distributes events round-robin across NUM_OUT replicated consumer handlers.
- Supports BUF links (tdata/tkeep/tlast, multi-beat packets) and STRUCT links (single-beat events).

Parameters:
- DATA_W, 512, tdata width in bits; 96/112/160/184 for STRUCT links.
- KEEP_W, DATA_W/8, tkeep width; used only when BUF_MODE=1.
- BUF_MODE, 1, 1: multi-beat packets delimited by tlast; 0: every beat is a complete event.
- DEPTH, 8, FIFO depth in beats; power of two, at least 2.
- NUM_OUT, 2, number of consumer replicas, 1..8.
- RR_SKIP, 0, 0: strict round-robin; 1: at a packet boundary, skip replicas whose tready is low.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_tdata  in  DATA_W  producer data.
- in_tkeep  in  KEEP_W  producer byte enables; ignored when BUF_MODE=0.
- in_tlast  in  1  producer end of packet; ignored when BUF_MODE=0.
- in_tvalid  in  1  producer valid.
- in_tready  out  1  space available in the FIFO.
- out_tdata  out  NUM_OUT*DATA_W  per-replica data; replica i occupies [i*DATA_W +: DATA_W].
- out_tkeep  out  NUM_OUT*KEEP_W  per-replica byte enables.
- out_tlast  out  NUM_OUT  per-replica end of packet.
- out_tvalid  out  NUM_OUT  per-replica valid; at most one bit set at any time.
- out_tready  in  NUM_OUT  per-replica ready.
- occupancy  out  $clog2(DEPTH+1)  number of beats currently stored.

Behaviour:
- Reset (rst=0, asynchronous): FIFO pointers, occupancy and sel are cleared, and all state is 0.
  - in_tready=0 while reset is asserted; it rises the first clk edge after release.
  - Any partially stored packet is discarded.
- Storage:
  - Stored word is {tdata, tkeep, tlast} when BUF_MODE=1, tdata only when BUF_MODE=0.
  - With BUF_MODE=0, out_tkeep is all-ones and out_tlast=1.
- Push occurs when in_tvalid & in_tready. in_tready is registered as (occupancy < DEPTH), so there is no combinational path from out_tready.
- Full boundary: in_tready deasserts when occupancy reaches DEPTH.
  - A pop in the cycle the FIFO becomes full is not visible to in_tready until the next cycle. One bubble is accepted in this case.
- Output is first-word-fall-through from the FIFO head.
  - Latency: a beat pushed at edge t drives out_tvalid[sel] after edge t (visible in cycle t+1).
  - Occupancy updates on the same edge.
- Pop occurs when out_tvalid[sel] & out_tready[sel].
- Simultaneous push and pop: occupancy is unchanged and both take effect.
- Dispatch FSM states:
  - IDLE: at a packet boundary, no beat of the current packet sent yet.
  - BURST: mid-packet; only reachable when BUF_MODE=1.
- IDLE transitions:
  - Head valid: choose the target replica.
    - RR_SKIP=0: target = sel.
    - RR_SKIP=1: target = first replica with out_tready high, searching from sel upward modulo NUM_OUT. If none is ready, target = sel.
  - Present the head only on out_tvalid[target]. All other out_tvalid bits are 0. out_tdata slices of non-targeted replicas may hold any value.
  - On a pop with tlast=1 or BUF_MODE=0: sel <= (target+1) mod NUM_OUT; stay in IDLE.
  - On a pop with tlast=0: latch target; go to BURST.
- BURST transitions:
  - The target is locked; no skipping and no re-arbitration. The head is held until the locked replica accepts it.
  - On a pop with tlast=1: sel <= (locked+1) mod NUM_OUT; go to IDLE.
  - If the FIFO runs empty mid-packet, out_tvalid drops and the FSM stays in BURST.
- Wrap-around:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Full and empty are derived from occupancy, not from pointer equality.
- tvalid/tdata contract:
  - Once out_tvalid[i] is asserted it stays high with stable tdata, tkeep and tlast until accepted.
  - In RR_SKIP=1, the target is committed (registered) once out_tvalid is raised, so the choice cannot change while waiting.
- NUM_OUT=1: sel is constant 0 and the block degenerates to a plain FIFO.

Decomposition:
- Package ep2_link_pkg:
  - link_mode_e {LINK_STRUCT, LINK_BUF}.
  - disp_state_e {DISP_IDLE, DISP_BURST}.
  - Function clog2_safe.
- Sub-module ep2_sync_fifo (WIDTH, DEPTH):
  - Single-clock FWFT FIFO with registered ready and occupancy output.
  - Reusable for the other inter-handler links.
- Dispatch FSM and round-robin selection live in ep2_event_dispatch.

Test Plan:
- BUF_MODE=1, NUM_OUT=2, RR_SKIP=0: push 3 packets of 2 beats each (tdata 0xA0,0xA1 / 0xB0,0xB1 / 0xC0,0xC1), all ready high.
  - Expect A on out0, B on out1, C on out0.
  - First beat appears 1 cycle after acceptance; tlast is set on the second beat of each packet.
- Full boundary, DEPTH=8, all out_tready=0: push 10 beats.
  - Expect 8 accepted, in_tready=0 with occupancy=8.
  - Raise out_tready: in_tready returns 1 cycle after the first pop.
- Mid-packet lock, RR_SKIP=1: start a 4-beat packet to out1, then drop out_tready[1] after beat 2 while out0 stays ready.
  - Expect beats 3-4 held on out1 and not diverted.
  - The next packet goes to out0.
- RR_SKIP=1, BUF_MODE=0, NUM_OUT=4, sel=1, out_tready=4'b1001.
  - Expect event on out3, then sel=0.
  - The next event goes to out0.
- Simultaneous push and pop at occupancy=3.
  - Expect occupancy stays 3 and order is preserved across pointer wrap over 20 beats, checked by a scoreboard.
- Assert rst=0 mid-packet (beat 2 of 4).
  - Expect out_tvalid=0 and occupancy=0 immediately.
  - After release, a new packet goes to out0 with no residual beats.

Source files
------------

// File: rtl/ep2_link_pkg.sv
// Shared types and helpers for the EP2 inter-handler links.
package ep2_link_pkg;

   typedef enum logic {LINK_STRUCT, LINK_BUF} link_mode_e;

   typedef enum logic {DISP_IDLE, DISP_BURST} disp_state_e;

   // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit index.
   function automatic int unsigned clog2_safe(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ep2_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered ready and occupancy.
module ep2_sync_fifo
   import ep2_link_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         push_valid,
   output logic                         push_ready,
   output logic [WIDTH-1:0]             head_data_c,
   output logic                         head_valid_c,
   input  logic                         pop,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = clog2_safe(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_nxt;
   logic             push;
   logic             pop_ok;

   assign push         = push_valid & push_ready;
   assign pop_ok       = pop & head_valid_c;
   assign head_valid_c = (count != '0);
   assign head_data_c  = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push && !pop_ok) begin
         count_nxt = count + CNT_W'(1);
      end else if (!push && pop_ok) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   // Ready looks at next occupancy, so a pop on the filling edge shows up one cycle late.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         push_ready <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count      <= count_nxt;
         push_ready <= (count_nxt < CNT_W'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/ep2_event_dispatch.sv
// Buffered EP2 link: FIFO plus round-robin dispatch to NUM_OUT consumer replicas.
module ep2_event_dispatch
   import ep2_link_pkg::*;
#(
   parameter int unsigned DATA_W   = 512,
   parameter int unsigned KEEP_W   = DATA_W / 8,
   parameter int unsigned BUF_MODE = 1,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned NUM_OUT  = 2,
   parameter int unsigned RR_SKIP  = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_W-1:0]            in_tdata,
   input  logic [KEEP_W-1:0]            in_tkeep,
   input  logic                         in_tlast,
   input  logic                         in_tvalid,
   output logic                         in_tready,
   output logic [NUM_OUT*DATA_W-1:0]    out_tdata,
   output logic [NUM_OUT*KEEP_W-1:0]    out_tkeep,
   output logic [NUM_OUT-1:0]           out_tlast,
   output logic [NUM_OUT-1:0]           out_tvalid,
   input  logic [NUM_OUT-1:0]           out_tready,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam link_mode_e  MODE   = (BUF_MODE != 0) ? LINK_BUF : LINK_STRUCT;
   localparam int unsigned WORD_W = (MODE == LINK_BUF) ? DATA_W + KEEP_W + 1 : DATA_W;
   localparam int unsigned SEL_W  = clog2_safe(NUM_OUT);

   logic [WORD_W-1:0] in_word;
   logic [WORD_W-1:0] head_word;
   logic              head_valid;
   logic [DATA_W-1:0] head_data;
   logic [KEEP_W-1:0] head_keep;
   logic              head_last;
   logic              pop;

   disp_state_e       state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [SEL_W-1:0]  tgt_q, tgt_d;
   logic              commit_q, commit_d;
   logic [SEL_W-1:0]  target;
   logic [SEL_W-1:0]  scan;
   logic              found;
   int unsigned       idx;
   logic [NUM_OUT-1:0] rdy_rot;

   generate
      if (MODE == LINK_BUF) begin : g_buf
         assign in_word = {in_tdata, in_tkeep, in_tlast};
         assign {head_data, head_keep, head_last} = head_word;
      end else begin : g_struct
         logic unused_sideband;
         assign unused_sideband = ^{in_tkeep, in_tlast};
         assign in_word   = in_tdata;
         assign head_data = head_word;
         assign head_keep = '1;
         assign head_last = 1'b1;
      end
   endgenerate

   ep2_sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst),
      .push_data    (in_word),
      .push_valid   (in_tvalid),
      .push_ready   (in_tready),
      .head_data_c  (head_word),
      .head_valid_c (head_valid),
      .pop          (pop),
      .count        (occupancy)
   );

   function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
      return (32'(s) == NUM_OUT - 1) ? '0 : s + SEL_W'(1);
   endfunction

   // First ready replica at or after sel, wrapping; falls back to sel.
   always_comb begin
      scan    = sel_q;
      found   = 1'b0;
      idx     = 0;
      rdy_rot = '0;
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
         idx     = (32'(sel_q) + k) % NUM_OUT;
         rdy_rot = out_tready >> idx;
         if (!found && rdy_rot[0]) begin
            scan  = SEL_W'(idx);
            found = 1'b1;
         end
      end
   end

   // Once presented (commit) or mid-packet (BURST) the target is frozen.
   always_comb begin
      if (state_q == DISP_BURST || commit_q) begin
         target = tgt_q;
      end else if (RR_SKIP != 0) begin
         target = scan;
      end else begin
         target = sel_q;
      end
   end

   assign out_tvalid = head_valid ? (NUM_OUT'(1) << target) : '0;
   assign pop        = |(out_tvalid & out_tready);
   assign out_tdata  = {NUM_OUT{head_data}};
   assign out_tkeep  = {NUM_OUT{head_keep}};
   assign out_tlast  = {NUM_OUT{head_last}};

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      tgt_d    = tgt_q;
      commit_d = commit_q;
      case (state_q)
         DISP_IDLE: begin
            if (pop) begin
               commit_d = 1'b0;
               if (head_last) begin
                  sel_d = next_sel(target);
               end else begin
                  tgt_d   = target;
                  state_d = DISP_BURST;
               end
            end else if (head_valid) begin
               commit_d = 1'b1;
               tgt_d    = target;
            end
         end
         DISP_BURST: begin
            if (pop && head_last) begin
               sel_d   = next_sel(tgt_q);
               state_d = DISP_IDLE;
            end
         end
         default: state_d = DISP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= DISP_IDLE;
         sel_q    <= '0;
         tgt_q    <= '0;
         commit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         tgt_q    <= tgt_d;
         commit_q <= commit_d;
      end
   end

endmodule

// File: tb/tb_ep2_event_dispatch.sv
// Scoreboard bench: a 2-replica BUF link and a 4-replica STRUCT link, both with ready skipping.
module tb_ep2_event_dispatch;

   typedef struct {
      int          rep;
      logic [15:0] data;
      logic [1:0]  keep;
      logic        last;
   } a_exp_t;

   typedef struct {
      int          rep;
      logic [95:0] data;
   } b_exp_t;

   logic clk;
   logic rst;

   logic [15:0] a_tdata;
   logic [1:0]  a_tkeep;
   logic        a_tlast, a_tvalid, a_tready;
   logic [31:0] a_dout;
   logic [3:0]  a_kout;
   logic [1:0]  a_lout, a_vout, a_ready;
   logic [3:0]  a_occ;

   logic [95:0]  b_tdata;
   logic [11:0]  b_tkeep;
   logic         b_tlast, b_tvalid, b_tready;
   logic [383:0] b_dout;
   logic [47:0]  b_kout;
   logic [3:0]   b_lout, b_vout, b_ready;
   logic [2:0]   b_occ;

   a_exp_t qa[$];
   b_exp_t qb[$];
   int n_checks = 0;
   int n_fail   = 0;

   ep2_event_dispatch #(.DATA_W(16), .KEEP_W(2), .BUF_MODE(1), .DEPTH(8),
                        .NUM_OUT(2), .RR_SKIP(1)) u_a (
      .clk(clk), .rst(rst),
      .in_tdata(a_tdata), .in_tkeep(a_tkeep), .in_tlast(a_tlast),
      .in_tvalid(a_tvalid), .in_tready(a_tready),
      .out_tdata(a_dout), .out_tkeep(a_kout), .out_tlast(a_lout),
      .out_tvalid(a_vout), .out_tready(a_ready), .occupancy(a_occ));

   ep2_event_dispatch #(.DATA_W(96), .KEEP_W(12), .BUF_MODE(0), .DEPTH(4),
                        .NUM_OUT(4), .RR_SKIP(1)) u_b (
      .clk(clk), .rst(rst),
      .in_tdata(b_tdata), .in_tkeep(b_tkeep), .in_tlast(b_tlast),
      .in_tvalid(b_tvalid), .in_tready(b_tready),
      .out_tdata(b_dout), .out_tkeep(b_kout), .out_tlast(b_lout),
      .out_tvalid(b_vout), .out_tready(b_ready), .occupancy(b_occ));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [3:0] v);
      int r = 0;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Pops are observed on the falling edge, i.e. the handshake that the next rising edge takes.
   logic        hold_pend = 1'b0;
   int          hold_idx;
   logic [15:0] hold_data;
   always @(negedge clk) begin
      if (!rst) begin
         hold_pend = 1'b0;
      end else begin
         a_exp_t ea;
         b_exp_t eb;
         int     i;
         check("a_onehot", 128'($countones(a_vout) <= 1), 1);
         check("b_onehot", 128'($countones(b_vout) <= 1), 1);
         if (hold_pend) begin
            check("a_hold_valid", 128'(a_vout[hold_idx]), 1);
            check("a_hold_data", a_dout[hold_idx*16 +: 16], hold_data);
         end
         i = onehot_idx({2'b00, a_vout});
         hold_pend = a_vout[i] && !a_ready[i];
         hold_idx  = i;
         hold_data = a_dout[i*16 +: 16];
         if (|(a_vout & a_ready)) begin
            if (qa.size() == 0) begin
               check("a_unexpected_beat", 1, 0);
            end else begin
               ea = qa.pop_front();
               check("a_replica", i, ea.rep);
               check("a_data", a_dout[i*16 +: 16], ea.data);
               check("a_keep", a_kout[i*2 +: 2], ea.keep);
               check("a_last", 128'(a_lout[i]), 128'(ea.last));
            end
         end
         if (|(b_vout & b_ready)) begin
            i = onehot_idx(b_vout);
            if (qb.size() == 0) begin
               check("b_unexpected_event", 1, 0);
            end else begin
               eb = qb.pop_front();
               check("b_replica", i, eb.rep);
               check("b_data", b_dout[i*96 +: 96], eb.data);
               check("b_keep", b_kout[i*12 +: 12], 12'hFFF);
               check("b_last", 128'(b_lout[i]), 1);
            end
         end
      end
   end

   task automatic send_a(input logic [15:0] d, input logic last, input int rep);
      int   waited = 0;
      logic ok;
      a_tdata  = d;
      a_tlast  = last;
      a_tkeep  = last ? 2'b01 : 2'b11;
      a_tvalid = 1'b1;
      qa.push_back('{rep, d, a_tkeep, last});
      do begin
         @(negedge clk);
         ok = a_tready;
         @(posedge clk);
         #1;
         waited++;
      end while (!ok && waited < 50);
      if (!ok) check("a_accept_timeout", 0, 1);
   endtask

   task automatic send_b(input logic [95:0] d, input int rep);
      int   waited = 0;
      logic ok;
      b_tdata  = d;
      b_tvalid = 1'b1;
      qb.push_back('{rep, d});
      do begin
         @(negedge clk);
         ok = b_tready;
         @(posedge clk);
         #1;
         waited++;
      end while (!ok && waited < 50);
      if (!ok) check("b_accept_timeout", 0, 1);
   endtask

   task automatic drain(input string tag);
      int waited = 0;
      while ((qa.size() != 0 || qb.size() != 0) && waited < 200) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check({tag, "_a_left"}, qa.size(), 0);
      check({tag, "_b_left"}, qb.size(), 0);
   endtask

   initial begin
      int rep;
      int acc;
      rst = 1'b0;
      a_tdata = '0; a_tkeep = '0; a_tlast = 1'b0; a_tvalid = 1'b0; a_ready = 2'b11;
      b_tdata = '0; b_tkeep = '0; b_tlast = 1'b0; b_tvalid = 1'b0; b_ready = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_tready", 128'(a_tready), 0);
      check("rst_a_occ", 128'(a_occ), 0);
      check("rst_a_tvalid", 128'(a_vout), 0);
      check("rst_b_tready", 128'(b_tready), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rel_a_tready", 128'(a_tready), 1);
      check("rel_b_tready", 128'(b_tready), 1);

      // Three 2-beat packets, everyone ready: A->0, B->1, C->0.
      send_a(16'h00A0, 1'b0, 0);
      check("lat_tvalid", 128'(a_vout), 2'b01);
      check("lat_tdata", 128'(a_dout[15:0]), 16'h00A0);
      send_a(16'h00A1, 1'b1, 0);
      send_a(16'h00B0, 1'b0, 1);
      send_a(16'h00B1, 1'b1, 1);
      send_a(16'h00C0, 1'b0, 0);
      send_a(16'h00C1, 1'b1, 0);
      a_tvalid = 1'b0;
      drain("rr");

      // Full boundary: nobody ready, offer 10 single-beat packets.
      a_ready = 2'b00;
      acc = 0;
      rep = 1;
      for (int k = 0; k < 10; k++) begin
         a_tdata  = 16'h0100 + 16'(k);
         a_tlast  = 1'b1;
         a_tkeep  = 2'b01;
         a_tvalid = 1'b1;
         @(negedge clk);
         if (a_tready) begin
            qa.push_back('{rep, a_tdata, 2'b01, 1'b1});
            rep = 1 - rep;
            acc++;
         end
         @(posedge clk);
         #1;
      end
      a_tvalid = 1'b0;
      check("full_accepted", acc, 8);
      check("full_occ", 128'(a_occ), 8);
      check("full_tready", 128'(a_tready), 0);
      a_ready = 2'b11;
      @(negedge clk);
      check("full_tready_hold", 128'(a_tready), 0);
      @(posedge clk);
      #1;
      check("full_tready_back", 128'(a_tready), 1);
      check("full_occ_pop", 128'(a_occ), 7);
      drain("full");

      // Mid-packet lock: 4-beat packet to out1, out1 stalls after beat 2.
      a_ready = 2'b00;
      send_a(16'h00D0, 1'b0, 1);
      send_a(16'h00D1, 1'b0, 1);
      send_a(16'h00D2, 1'b0, 1);
      send_a(16'h00D3, 1'b1, 1);
      send_a(16'h00E0, 1'b1, 0);
      a_tvalid = 1'b0;
      a_ready = 2'b10;
      repeat (2) @(posedge clk);
      #1;
      a_ready = 2'b01;
      repeat (3) begin
         @(negedge clk);
         check("lock_tvalid", 128'(a_vout), 2'b10);
         check("lock_tdata", 128'(a_dout[31:16]), 16'h00D2);
      end
      @(posedge clk);
      #1;
      a_ready = 2'b11;
      drain("lock");

      // Concurrent push and pop at occupancy 3 across pointer wrap.
      a_ready = 2'b00;
      rep = 1;
      for (int k = 0; k < 3; k++) begin
         send_a(16'h3000 + 16'(k), 1'b1, rep);
         rep = 1 - rep;
      end
      check("stream_pre_occ", 128'(a_occ), 3);
      a_ready = 2'b11;
      for (int k = 3; k < 23; k++) begin
         send_a(16'h3000 + 16'(k), 1'b1, rep);
         rep = 1 - rep;
         check("stream_occ", 128'(a_occ), 3);
      end
      a_tvalid = 1'b0;
      drain("stream");

      // STRUCT link with skipping: sel=1, ready=1001 -> out3, then out0.
      send_b(96'h1111_0000_0000_0000_0000_0001, 0);
      b_tvalid = 1'b0;
      drain("struct_pre");
      b_ready = 4'b1001;
      send_b(96'h2222_0000_0000_0000_0000_0002, 3);
      send_b(96'h3333_0000_0000_0000_0000_0003, 0);
      b_tvalid = 1'b0;
      drain("struct_skip");

      // Reset while beat 2 of a 4-beat packet waits at the head.
      a_ready = 2'b00;
      send_a(16'h00F0, 1'b0, 0);
      send_a(16'h00F1, 1'b0, 0);
      send_a(16'h00F2, 1'b0, 0);
      send_a(16'h00F3, 1'b1, 0);
      a_tvalid = 1'b0;
      a_ready = 2'b01;
      @(posedge clk);
      #1;
      a_ready = 2'b00;
      check("pre_rst_occ", 128'(a_occ), 3);
      rst = 1'b0;
      #1;
      check("rst_mid_tvalid", 128'(a_vout), 0);
      check("rst_mid_occ", 128'(a_occ), 0);
      check("rst_mid_tready", 128'(a_tready), 0);
      qa.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      a_ready = 2'b11;
      @(posedge clk);
      #1;
      send_a(16'h0070, 1'b0, 0);
      send_a(16'h0071, 1'b1, 0);
      a_tvalid = 1'b0;
      drain("post_rst");
      repeat (5) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      check("watchdog", 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
